// File: rtl/fetch_pkg.sv
// Shared defaults and elaboration helpers for the instruction fetch unit.
package fetch_pkg;

  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_FLASH_LAT = 1;
  localparam int DEF_RESET_PC  = 0;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush and occupancy count; the output holds the last
// head value while empty.
module sync_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_DATA_W + DEF_ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [WIDTH-1:0]              din,
  input  logic                          pop,
  input  logic                          flush,
  output logic                          valid,
  output logic [WIDTH-1:0]              dout,
  output logic [clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [WIDTH-1:0] hold;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign do_pop  = pop && valid && !flush;
  assign do_push = push && !flush && ((count != CW'(DEPTH)) || do_pop);
  assign dout    = valid ? mem[rd_ptr] : hold;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      hold   <= '0;
    end else begin
      // dout already equals hold when empty, so this keeps the last head.
      hold <= dout;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        if (do_push && !do_pop)      count <= count + CW'(1);
        else if (!do_push && do_pop) count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, credit-based flash request issue, in-flight
// tag pipeline and an instruction queue in front of the consumer.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int FLASH_LAT = DEF_FLASH_LAT,
  parameter int RESET_PC  = DEF_RESET_PC
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          flash_rd,
  output logic [ADDR_W-1:0]             flash_addr,
  input  logic [DATA_W-1:0]             flash_data,
  input  logic                          br_take,
  input  logic [ADDR_W-1:0]             br_target,
  input  logic                          stall,
  input  logic                          ir_ready,
  output logic                          ir_valid,
  output logic [DATA_W-1:0]             ir_data,
  output logic [ADDR_W-1:0]             ir_pc,
  output logic [clog2(DEPTH+1)-1:0]     level
);

  localparam int LVL_W = clog2(DEPTH + 1);
  localparam int CRD_W = LVL_W + 1;

  logic [ADDR_W-1:0]        pc;
  logic                     tag_vld [FLASH_LAT];
  logic [ADDR_W-1:0]        tag_pc  [FLASH_LAT];
  logic [CRD_W-1:0]         in_flight;
  logic [CRD_W-1:0]         credit_used;
  logic                     pop;
  logic                     arrive;
  logic                     issue;
  logic [DATA_W+ADDR_W-1:0] head;

  assign pop    = ir_valid && ir_ready;
  assign arrive = tag_vld[FLASH_LAT-1];

  // The slot freed by this cycle's pop is credited immediately so that
  // DEPTH = FLASH_LAT+1 still sustains one word per cycle.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < FLASH_LAT; i++) begin
      in_flight = in_flight + CRD_W'(tag_vld[i]);
    end
    credit_used = CRD_W'(level) + in_flight - CRD_W'(pop);
    issue       = rst && !stall && !br_take && (credit_used < CRD_W'(DEPTH));
  end

  assign flash_rd   = issue;
  assign flash_addr = pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= ADDR_W'(RESET_PC);
      for (int i = 0; i < FLASH_LAT; i++) begin
        tag_vld[i] <= 1'b0;
        tag_pc[i]  <= '0;
      end
    end else begin
      if (br_take)    pc <= br_target;
      else if (issue) pc <= pc + ADDR_W'(1);
      // issue is already low under br_take, so stage 0 clears with the rest.
      tag_vld[0] <= issue;
      tag_pc[0]  <= pc;
      for (int i = 1; i < FLASH_LAT; i++) begin
        tag_vld[i] <= br_take ? 1'b0 : tag_vld[i-1];
        tag_pc[i]  <= tag_pc[i-1];
      end
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + ADDR_W)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (arrive),
    .din   ({tag_pc[FLASH_LAT-1], flash_data}),
    .pop   (pop),
    .flush (br_take),
    .valid (ir_valid),
    .dout  (head),
    .count (level)
  );

  assign ir_pc   = head[DATA_W +: ADDR_W];
  assign ir_data = head[DATA_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: one instance with flash latency 1 and one with
// latency 3 share stimulus; each has its own flash model and expected-PC queue.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic br_take = 1'b0;
  logic [9:0] br_target = '0;
  logic stall = 1'b0;
  logic ir_ready = 1'b0;

  logic        flash_rd   [2];
  logic [9:0]  flash_addr [2];
  logic [31:0] flash_data [2];
  logic        ir_valid   [2];
  logic [31:0] ir_data    [2];
  logic [9:0]  ir_pc      [2];
  logic [2:0]  level      [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(10), .DATA_W(32), .DEPTH(4), .FLASH_LAT(1), .RESET_PC(0)) u_lat1 (
    .clk(clk), .rst(rst), .flash_rd(flash_rd[0]), .flash_addr(flash_addr[0]),
    .flash_data(flash_data[0]), .br_take(br_take), .br_target(br_target), .stall(stall),
    .ir_ready(ir_ready), .ir_valid(ir_valid[0]), .ir_data(ir_data[0]), .ir_pc(ir_pc[0]),
    .level(level[0]));

  fetch_unit #(.ADDR_W(10), .DATA_W(32), .DEPTH(4), .FLASH_LAT(3), .RESET_PC(0)) u_lat3 (
    .clk(clk), .rst(rst), .flash_rd(flash_rd[1]), .flash_addr(flash_addr[1]),
    .flash_data(flash_data[1]), .br_take(br_take), .br_target(br_target), .stall(stall),
    .ir_ready(ir_ready), .ir_valid(ir_valid[1]), .ir_data(ir_data[1]), .ir_pc(ir_pc[1]),
    .level(level[1]));

  // Flash models: word at address a reads as a + 0x1000, FLASH_LAT cycles later.
  logic [9:0] fa1;
  logic [9:0] fa3 [3];
  always @(posedge clk) begin
    fa1    <= flash_addr[0];
    fa3[0] <= flash_addr[1];
    fa3[1] <= fa3[0];
    fa3[2] <= fa3[1];
  end
  assign flash_data[0] = 32'h1000 + {22'b0, fa1};
  assign flash_data[1] = 32'h1000 + {22'b0, fa3[2]};

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[lat%0d] t=%0t: got %0h expected %0h", nm, (k == 0) ? 1 : 3, $time, act, exp);
    end
  endtask

  // Expected delivered-PC streams, rebuilt whenever fetch is redirected.
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic [9:0] tail0, tail1;
  bit         pend = 1'b1;
  logic [9:0] pend_t = '0;

  task automatic topup();
    while (q0.size() < 16) begin q0.push_back(tail0); tail0 = tail0 + 10'd1; end
    while (q1.size() < 16) begin q1.push_back(tail1); tail1 = tail1 + 10'd1; end
  endtask

  task automatic reload(input logic [9:0] t);
    q0.delete();
    q1.delete();
    tail0 = t;
    tail1 = t;
    topup();
  endtask

  task automatic pop_exp(input int k, output logic [9:0] v, output bit ok);
    ok = 1'b1;
    v  = '0;
    if (k == 0) begin
      if (q0.size() == 0) ok = 1'b0; else v = q0.pop_front();
    end else begin
      if (q1.size() == 0) ok = 1'b0; else v = q1.pop_front();
    end
  endtask

  // Monitor: samples on the falling edge what the next rising edge will act on.
  logic [9:0]  exp_addr  [2];
  bit          flush_chk [2];
  int          issue_cnt [2];
  logic [31:0] last_data [2];
  logic [9:0]  last_pc   [2];
  bit          rst_prev = 1'b0;

  always @(negedge clk) begin
    logic [9:0] e;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        chk("rd_in_reset", k, flash_rd[k], 1'b0);
        if (!rst_prev) begin
          chk("rst_valid", k, ir_valid[k], 1'b0);
          chk("rst_data",  k, ir_data[k], 32'h0);
          chk("rst_pc",    k, ir_pc[k], 10'h0);
          chk("rst_level", k, level[k], 3'd0);
          chk("rst_addr",  k, flash_addr[k], 10'h0);
        end
        exp_addr[k]  = 10'h0;
        flush_chk[k] = 1'b0;
        issue_cnt[k] = 0;
        last_data[k] = 32'h0;
        last_pc[k]   = 10'h0;
      end else begin
        if (flush_chk[k]) begin
          chk("valid_after_flush", k, ir_valid[k], 1'b0);
          chk("level_after_flush", k, level[k], 3'd0);
        end
        chk("valid_vs_level", k, ir_valid[k], level[k] != 3'd0);
        chk("level_bound", k, level[k] <= 3'd4, 1'b1);
        if (stall || br_take) chk("rd_blocked", k, flash_rd[k], 1'b0);
        if (flash_rd[k]) begin
          chk("issue_addr", k, flash_addr[k], exp_addr[k]);
          issue_cnt[k] = issue_cnt[k] + 1;
        end
        if (br_take)          exp_addr[k] = br_target;
        else if (flash_rd[k]) exp_addr[k] = flash_addr[k] + 10'd1;
        if (!ir_valid[k]) begin
          chk("hold_data", k, ir_data[k], last_data[k]);
          chk("hold_pc",   k, ir_pc[k], last_pc[k]);
        end else begin
          last_data[k] = ir_data[k];
          last_pc[k]   = ir_pc[k];
          if (ir_ready) begin
            pop_exp(k, e, ok);
            chk("scoreboard_nonempty", k, ok, 1'b1);
            chk("pop_pc",   k, ir_pc[k], e);
            chk("pop_data", k, ir_data[k], 32'h1000 + {22'b0, e});
          end
        end
        flush_chk[k] = br_take;
      end
    end
    rst_prev = rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
    br_take = 1'b0;
    if (pend) begin reload(pend_t); pend = 1'b0; end
    topup();
  endtask

  task automatic drive(input bit r, input bit bt, input logic [9:0] tgt, input bit st, input bit rdy);
    rst       = r;
    br_take   = r & bt;
    br_target = tgt;
    stall     = st;
    ir_ready  = rdy;
    if (!r) begin pend = 1'b1; pend_t = 10'h0; end
    else if (bt) begin pend = 1'b1; pend_t = tgt; end
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 10'h0, 1'b0, 1'b1);
    step();
    step();
  endtask

  initial begin
    logic [9:0] e;
    reload(10'h0);
    drive(1'b0, 1'b0, 10'h0, 1'b0, 1'b0);
    repeat (3) step();

    // Release with consumer ready: request at cycle 0, first word at cycle 2.
    drive(1'b1, 1'b0, 10'h0, 1'b0, 1'b1);
    @(negedge clk);
    chk("first_rd", 0, flash_rd[0], 1'b1);
    chk("first_addr", 0, flash_addr[0], 10'h0);
    step();
    @(negedge clk);
    chk("c1_valid", 0, ir_valid[0], 1'b0);
    step();
    @(negedge clk);
    chk("c2_valid", 0, ir_valid[0], 1'b1);
    chk("c2_data", 0, ir_data[0], 32'h1000);
    chk("c2_pc", 0, ir_pc[0], 10'h0);
    repeat (10) step();

    // Consumer held off: queue fills to DEPTH and issue stops at 4 requests.
    do_reset();
    drive(1'b1, 1'b0, 10'h0, 1'b0, 1'b0);
    repeat (9) step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("full_issues", k, issue_cnt[k], 4);
      chk("full_level", k, level[k], 3'd4);
      chk("full_no_rd", k, flash_rd[k], 1'b0);
    end
    step();
    drive(1'b1, 1'b0, 10'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("drain_valid", 0, ir_valid[0], 1'b1);
      chk("drain_pc", 0, ir_pc[0], 10'(i));
      step();
    end

    // Redirect with 3 queued and 1 in flight.
    do_reset();
    drive(1'b1, 1'b0, 10'h0, 1'b0, 1'b0);
    repeat (4) step();
    drive(1'b1, 1'b1, 10'h200, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_flush_level", 0, level[0], 3'd3);
    step();
    drive(1'b1, 1'b0, 10'h0, 1'b0, 1'b1);
    @(negedge clk);
    chk("flush_c1_valid", 0, ir_valid[0], 1'b0);
    step();
    @(negedge clk);
    chk("flush_c2_valid", 0, ir_valid[0], 1'b0);
    step();
    @(negedge clk);
    chk("flush_c3_valid", 0, ir_valid[0], 1'b1);
    chk("flush_c3_pc", 0, ir_pc[0], 10'h200);
    repeat (6) step();

    // Redirect coinciding with the pop of pc 5.
    do_reset();
    drive(1'b1, 1'b0, 10'h0, 1'b0, 1'b1);
    repeat (7) step();
    drive(1'b1, 1'b1, 10'h123, 1'b0, 1'b1);
    @(negedge clk);
    chk("pop5_valid", 0, ir_valid[0], 1'b1);
    chk("pop5_pc", 0, ir_pc[0], 10'h5);
    repeat (8) step();

    // PC wrap at the top of the address space.
    drive(1'b1, 1'b1, 10'h3FE, 1'b0, 1'b1);
    repeat (3) step();
    e = 10'h3FE;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wrap_pc", 0, ir_pc[0], e);
      e = e + 10'd1;
      step();
    end

    // Latency 3: sustained throughput, then reset with requests in flight.
    do_reset();
    drive(1'b1, 1'b0, 10'h0, 1'b0, 1'b1);
    repeat (4) step();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("lat3_stream_valid", 1, ir_valid[1], 1'b1);
      chk("lat3_stream_rd", 1, flash_rd[1], 1'b1);
      step();
    end
    drive(1'b0, 1'b0, 10'h0, 1'b0, 1'b1);
    step();
    @(negedge clk);
    chk("midrst_valid", 1, ir_valid[1], 1'b0);
    chk("midrst_level", 1, level[1], 3'd0);
    step();
    drive(1'b1, 1'b0, 10'h0, 1'b0, 1'b1);
    @(negedge clk);
    chk("post_rst_rd", 1, flash_rd[1], 1'b1);
    chk("post_rst_addr", 1, flash_addr[1], 10'h0);
    repeat (10) step();

    // Randomized traffic: stalls, backpressure, redirects and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      drive(1'b1, $urandom_range(0, 19) == 0, 10'($urandom), $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) < 7);
      step();
    end
    drive(1'b1, 1'b0, 10'h0, 1'b0, 1'b1);
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
